// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit scheduler.
//   state_e        : scheduler FSM states
//   *_HDR_BYTES    : header sizes used to derive the UDP/IP length fields
//   SRC_*          : source indices (radar stream, status/command path)
//   udp_len/ip_len : length field helpers from a payload word count
package udp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StLoad,
        StStart,
        StBusy,
        StGap
    } state_e;

    localparam int unsigned UDP_HDR_BYTES = 8;
    localparam int unsigned IP_HDR_BYTES  = 20;

    localparam int unsigned SRC_RADAR  = 0;
    localparam int unsigned SRC_STATUS = 1;

    // UDP length in bytes for a payload of 'words' 32-bit words.
    function automatic logic [15:0] udp_len(input logic [15:0] words);
        return 16'(UDP_HDR_BYTES) + (words << 2);
    endfunction

    // IP total length in bytes for a payload of 'words' 32-bit words.
    function automatic logic [15:0] ip_len(input logic [15:0] words);
        return udp_len(words) + 16'(IP_HDR_BYTES);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_i[1:0]  : request levels
//   upd_i       : record a completed service this cycle
//   upd_idx_i   : index of the source that was just served
//   gnt_o[1:0]  : one-hot grant (combinational), zero when nothing requests
// The last-served pointer resets to 1 so source 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_idx_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (upd_i) begin
            last_d = upd_idx_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    // On a tie the source not served last wins; otherwise the lone requester.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Shares the GMII UDP frame transmitter between the radar stream (source 0)
// and the status/command path (source 1): round-robin grant, length field
// derivation, start strobe, word-request steering, end-of-frame detection
// and inter-frame gap.
//
// Optional build macro UDP_TX_SCHED_TIMEOUT_EN compiles in the START timeout
// and the BUSY watchdog; without it START waits for txen indefinitely.
//
// Ports:
//   clk, rst_n                    : clock (rising edge), async active-low reset
//   src_req_i[1:0]                : per-source request level
//   src_words0_i, src_words1_i    : payload length in 32-bit words
//   src_data0_i, src_data1_i      : show-ahead head word of each source FIFO
//   src_rd_o[1:0]                 : per-source FIFO read strobe
//   src_done_o, src_rej_o [1:0]   : one-cycle completion / rejection pulses
//   tx_start_o                    : start strobe to the transmitter
//   tx_data_length_o              : UDP length in bytes
//   tx_total_length_o             : IP total length in bytes
//   data_req_i                    : word request from the transmitter
//   datain_o                      : word to the transmitter
//   txen_i                        : transmitter GMII enable
//   grant_o[1:0]                  : one-hot owner, zero when idle
//   busy_o                        : high outside IDLE
//   err_o                         : sticky error flag
//   frame_cnt_o                   : completed frame count (wraps)
module udp_tx_scheduler
    import udp_pkg::*;
#(
    parameter int unsigned MAX_WORDS     = 256,
    parameter int unsigned IFG_CYCLES    = 16,
    parameter int unsigned START_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  src_req_i,
    input  logic [15:0] src_words0_i,
    input  logic [15:0] src_words1_i,
    input  logic [31:0] src_data0_i,
    input  logic [31:0] src_data1_i,
    output logic [1:0]  src_rd_o,
    output logic [1:0]  src_done_o,
    output logic [1:0]  src_rej_o,
    output logic        tx_start_o,
    output logic [15:0] tx_data_length_o,
    output logic [15:0] tx_total_length_o,
    input  logic        data_req_i,
    output logic [31:0] datain_o,
    input  logic        txen_i,
    output logic [1:0]  grant_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [15:0] frame_cnt_o
);

    // One shared interval timer, sized for the longest interval it may time.
    localparam int unsigned WdMax   = 16 * (MAX_WORDS + 30);
    localparam int unsigned TmrMax0 = (WdMax > START_TIMEOUT) ? WdMax : START_TIMEOUT;
    localparam int unsigned TmrMax  = (TmrMax0 > IFG_CYCLES) ? TmrMax0 : IFG_CYCLES;
    localparam int unsigned TmrW    = $clog2(TmrMax + 1);

    localparam logic [15:0]     MaxWords = 16'(MAX_WORDS);
    localparam logic [TmrW-1:0] IfgLast  = TmrW'(IFG_CYCLES - 1);

    state_e state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [15:0]     words_q, words_d;
    logic [15:0]     wcnt_q, wcnt_d;
    logic [15:0]     udp_len_q, udp_len_d;
    logic [15:0]     ip_len_q, ip_len_d;
    logic [1:0]      done_q, done_d;
    logic [1:0]      rej_q, rej_d;
    logic            err_q, err_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            txen_q;

    logic [1:0]  arb_gnt;
    logic        arb_upd;
    logic [15:0] sel_words;
    logic [31:0] sel_data;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (src_req_i),
        .upd_i     (arb_upd),
        .upd_idx_i (grant_q[SRC_STATUS]),
        .gnt_o     (arb_gnt)
    );

    assign sel_words = grant_q[SRC_STATUS] ? src_words1_i : src_words0_i;
    assign sel_data  = grant_q[SRC_STATUS] ? src_data1_i : src_data0_i;

`ifdef UDP_TX_SCHED_TIMEOUT_EN
    localparam logic [TmrW-1:0] StartLast = TmrW'(START_TIMEOUT - 1);
    logic [TmrW-1:0] wd_lim;
    assign wd_lim = TmrW'((32'(words_q) + 32'd30) << 4);
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        words_d     = words_q;
        wcnt_d      = wcnt_q;
        udp_len_d   = udp_len_q;
        ip_len_d    = ip_len_q;
        done_d      = 2'b00;
        rej_d       = 2'b00;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        arb_upd     = 1'b0;
        src_rd_o    = 2'b00;
        datain_o    = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (|src_req_i) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                grant_d = arb_gnt;
                state_d = (|arb_gnt) ? StLoad : StIdle;
            end
            StLoad: begin
                // Rejection leaves the last-served pointer untouched.
                if (sel_words == 16'd0 || sel_words > MaxWords) begin
                    rej_d   = grant_q;
                    grant_d = 2'b00;
                    state_d = StIdle;
                end else begin
                    words_d   = sel_words;
                    udp_len_d = udp_len(sel_words);
                    ip_len_d  = ip_len(sel_words);
                    wcnt_d    = 16'd0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (txen_i) begin
                    state_d = StBusy;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
                end else if (tmr_q == StartLast) begin
                    err_d   = 1'b1;
                    rej_d   = grant_q;
                    state_d = StGap;
`endif
                end
            end
            StBusy: begin
                if (data_req_i) begin
                    // Requests beyond the announced length are starved and flagged.
                    if (wcnt_q < words_q) begin
                        src_rd_o = grant_q;
                        datain_o = sel_data;
                        wcnt_d   = wcnt_q + 16'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (txen_q && !txen_i) begin
                    done_d      = grant_q;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    arb_upd     = 1'b1;
                    state_d     = StGap;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
                end else if (tmr_q >= wd_lim) begin
                    err_d   = 1'b1;
                    rej_d   = grant_q;
                    state_d = StGap;
`endif
                end
            end
            StGap: begin
                if (tmr_q == IfgLast) begin
                    grant_d = 2'b00;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Timer restarts on every state change, so each state times from entry.
    assign tmr_d = (state_d != state_q) ? '0 : tmr_q + TmrW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_q     <= 2'b00;
            words_q     <= 16'd0;
            wcnt_q      <= 16'd0;
            udp_len_q   <= 16'd0;
            ip_len_q    <= 16'd0;
            done_q      <= 2'b00;
            rej_q       <= 2'b00;
            err_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
            tmr_q       <= '0;
            txen_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            words_q     <= words_d;
            wcnt_q      <= wcnt_d;
            udp_len_q   <= udp_len_d;
            ip_len_q    <= ip_len_d;
            done_q      <= done_d;
            rej_q       <= rej_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            tmr_q       <= tmr_d;
            txen_q      <= txen_i;
        end
    end

    assign tx_start_o        = (state_q == StStart);
    assign busy_o            = (state_q != StIdle);
    assign grant_o           = grant_q;
    assign src_done_o        = done_q;
    assign src_rej_o         = rej_q;
    assign err_o             = err_q;
    assign frame_cnt_o       = frame_cnt_q;
    assign tx_data_length_o  = udp_len_q;
    assign tx_total_length_o = ip_len_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed bench for udp_tx_scheduler with a transmitter model, source FIFO
// models and a transaction-level reference for grant, read strobes and data.
module tb_udp_tx_scheduler;

    localparam logic [31:0] BASE0 = 32'hA000_0000;
    localparam logic [31:0] BASE1 = 32'h5000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  src_req;
    logic [15:0] words0, words1;
    logic [31:0] data0, data1;
    logic [1:0]  src_rd_o, src_done_o, src_rej_o, grant_o;
    logic        tx_start_o, busy_o, err_o;
    logic [15:0] tx_data_length_o, tx_total_length_o, frame_cnt_o;
    logic        data_req, txen;
    logic [31:0] datain_o;

    always #5 clk = ~clk;

    udp_tx_scheduler dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .src_req_i         (src_req),
        .src_words0_i      (words0),
        .src_words1_i      (words1),
        .src_data0_i       (data0),
        .src_data1_i       (data1),
        .src_rd_o          (src_rd_o),
        .src_done_o        (src_done_o),
        .src_rej_o         (src_rej_o),
        .tx_start_o        (tx_start_o),
        .tx_data_length_o  (tx_data_length_o),
        .tx_total_length_o (tx_total_length_o),
        .data_req_i        (data_req),
        .datain_o          (datain_o),
        .txen_i            (txen),
        .grant_o           (grant_o),
        .busy_o            (busy_o),
        .err_o             (err_o),
        .frame_cnt_o       (frame_cnt_o)
    );

    // Show-ahead source FIFOs: head word is base + number of pops so far.
    logic [31:0] pop0 = 32'd0;
    logic [31:0] pop1 = 32'd0;
    always @(posedge clk) begin
        if (src_rd_o[0]) pop0 <= pop0 + 32'd1;
        if (src_rd_o[1]) pop1 <= pop1 + 32'd1;
    end
    assign data0 = BASE0 + pop0;
    assign data1 = BASE1 + pop1;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state: owner of the current frame, its length, words handed out.
    bit          in_frame;
    int          exp_owner;
    int          exp_w;
    int          word_idx;
    int          last_served;
    logic [31:0] exp_pop[2];
    time         last_fall;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [1:0] req, input int last);
        if (req == 2'b11) return (last == 0) ? 1 : 0;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tx_start", tx_start_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_src_rd", src_rd_o, 0);
        chk("rst_src_done", src_done_o, 0);
        chk("rst_src_rej", src_rej_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_frame_cnt", frame_cnt_o, 0);
        chk("rst_udp_len", tx_data_length_o, 0);
        chk("rst_ip_len", tx_total_length_o, 0);
        chk("rst_datain", datain_o, 0);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        tick(2);
        rst_n = 1'b1;
        in_frame = 1'b0;
        last_served = 1;
        tick(1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy_o && t < 60) begin
            tick(1);
            t++;
        end
        chk("return_idle", busy_o, 0);
    endtask

    // Transmitter model: waits for tx_start, raises txen, issues nreq word
    // requests, drops txen and waits for src_done. abort_at >= 0 resets the
    // system in the middle of that word request instead.
    task automatic run_frame(input int nreq, input int abort_at, input bit meas_gap,
                             output logic [1:0] gnt_seen, output int done_cnt);
        int t;
        int gap;
        gnt_seen = 2'b00;
        done_cnt = 0;
        t = 0;
        while (!tx_start_o && t < 40) begin
            tick(1);
            t++;
        end
        chk("tx_start_rise", tx_start_o, 1);
        if (!tx_start_o) return;
        gnt_seen  = grant_o;
        exp_owner = rr_pick(src_req, last_served);
        exp_w     = (exp_owner == 1) ? int'(words1) : int'(words0);
        word_idx  = 0;
        in_frame  = 1'b1;
        if (meas_gap) begin
            gap = int'(($time - last_fall) / 10);
            chk("ifg_at_least_16", (gap >= 16), 1);
        end
        txen = 1'b1;
        tick(2);
        for (int i = 0; i < nreq; i++) begin
            data_req = 1'b1;
            if (i == abort_at) begin
                #2 rst_n = 1'b0;
                #1 chk_reset_outputs();
                txen        = 1'b0;
                data_req    = 1'b0;
                in_frame    = 1'b0;
                last_served = 1;
                return;
            end
            tick(1);
        end
        data_req = 1'b0;
        tick(2);
        txen = 1'b0;
        last_fall = $time;
        t = 0;
        while (done_cnt == 0 && t < 6) begin
            tick(1);
            t++;
            if (src_done_o != 2'b00) begin
                done_cnt++;
                chk("done_owner", src_done_o, longint'(1) << exp_owner);
            end
        end
        if (done_cnt != 0) last_served = exp_owner;
        in_frame = 1'b0;
    endtask

    // Per-cycle compare, sampled 1 ns before each rising edge.
    initial begin
        logic [1:0]  erd;
        logic [31:0] edat;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) begin
                erd  = 2'b00;
                edat = 32'd0;
                if (in_frame && data_req && word_idx < exp_w) begin
                    erd  = 2'(1 << exp_owner);
                    edat = ((exp_owner == 1) ? BASE1 : BASE0) + exp_pop[exp_owner];
                    exp_pop[exp_owner] = exp_pop[exp_owner] + 32'd1;
                end
                if (in_frame && data_req) word_idx++;
                chk("src_rd", src_rd_o, erd);
                chk("datain", datain_o, edat);
                chk("grant_onehot0", $onehot0(grant_o), 1);
                if (in_frame) chk("grant_owner", grant_o, longint'(1) << exp_owner);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [1:0]  g;
        int          dc;
        int          t;
        logic [31:0] p0;
        bit          started;
        logic [1:0]  exp_seq[4];
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst_n = 1'b0;
        src_req = 2'b00;
        words0 = 16'd0;
        words1 = 16'd0;
        data_req = 1'b0;
        txen = 1'b0;
        in_frame = 1'b0;
        last_served = 1;
        exp_pop[0] = 32'd0;
        exp_pop[1] = 32'd0;
        last_fall = 0;
        #1 chk_reset_outputs();
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Single radar frame, W = 64.
        words0 = 16'd64;
        src_req = 2'b01;
        t = 0;
        while (!tx_start_o && t < 10) begin
            tick(1);
            t++;
        end
        chk("start_latency", t, 3);
        chk("udp_len_64", tx_data_length_o, 264);
        chk("ip_len_64", tx_total_length_o, 284);
        p0 = pop0;
        run_frame(64, -1, 1'b0, g, dc);
        src_req = 2'b00;
        chk("grant_single", g, 2'b01);
        chk("rd0_pulses", pop0 - p0, 64);
        chk("done_once", dc, 1);
        chk("frame_cnt_1", frame_cnt_o, 1);
        chk("udp_len_stable", tx_data_length_o, 264);
        wait_idle();

        // Both sources request continuously: grants alternate.
        rst_pulse();
        words0 = 16'd4;
        words1 = 16'd4;
        src_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            run_frame(4, -1, (i > 0), g, dc);
            chk("rr_grant", g, exp_seq[i]);
            chk("rr_done", dc, 1);
        end
        src_req = 2'b00;
        wait_idle();
        chk("frame_cnt_4", frame_cnt_o, 4);

        // Length rejections on source 1: W = 0, then W = 257.
        for (int k = 0; k < 2; k++) begin
            words1 = (k == 0) ? 16'd0 : 16'd257;
            src_req = 2'b10;
            started = 1'b0;
            t = 0;
            while (src_rej_o == 2'b00 && t < 10) begin
                tick(1);
                t++;
                if (tx_start_o) started = 1'b1;
            end
            chk("rej_latency", t, 3);
            chk("rej_value", src_rej_o, 2'b10);
            src_req = 2'b00;
            tick(1);
            chk("rej_no_start", started, 0);
            chk("rej_no_err", err_o, 0);
            chk("rej_idle", busy_o, 0);
        end

        // Overrun: five word requests against W = 4.
        words0 = 16'd4;
        src_req = 2'b01;
        p0 = pop0;
        run_frame(5, -1, 1'b0, g, dc);
        src_req = 2'b00;
        chk("ovr_grant", g, 2'b01);
        chk("ovr_rd_pulses", pop0 - p0, 4);
        chk("ovr_err", err_o, 1);
        chk("ovr_done", dc, 1);
        chk("ovr_frame_cnt", frame_cnt_o, 5);
        wait_idle();

`ifdef UDP_TX_SCHED_TIMEOUT_EN
        // txen never rises: START times out after 64 clocks.
        rst_pulse();
        words0 = 16'd4;
        src_req = 2'b01;
        t = 0;
        while (!tx_start_o && t < 10) begin
            tick(1);
            t++;
        end
        chk("tmo_start_latency", t, 3);
        t = 0;
        while (!err_o && t < 100) begin
            tick(1);
            t++;
        end
        chk("tmo_cycles", t, 64);
        chk("tmo_rej", src_rej_o, 2'b01);
        src_req = 2'b00;
        wait_idle();
        chk("tmo_err_sticky", err_o, 1);
        chk("tmo_no_frame", frame_cnt_o, 0);
`endif

        // Reset mid-frame, then a tie goes to source 0 again.
        words0 = 16'd4;
        src_req = 2'b01;
        run_frame(4, -1, 1'b0, g, dc);
        src_req = 2'b00;
        wait_idle();
        words1 = 16'd8;
        src_req = 2'b10;
        run_frame(8, 2, 1'b0, g, dc);
        chk("pre_abort_grant", g, 2'b10);
        src_req = 2'b00;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        src_req = 2'b11;
        run_frame(4, -1, 1'b0, g, dc);
        src_req = 2'b00;
        chk("post_reset_grant", g, 2'b01);
        chk("post_reset_done", dc, 1);
        wait_idle();
        chk("post_reset_frame_cnt", frame_cnt_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_tx_scheduler.md
# udp_tx_scheduler

Sequences the GMII UDP frame transmitter and shares it between two payload sources: the radar sample stream (source 0) and the status/command-response path (source 1). It arbitrates round-robin between them and derives the UDP and IP length fields from the granted request. It issues the transmitter's start strobe, steers the transmitter's word requests to the granted source, detects end of frame, and enforces an inter-frame gap.

## Interface
- `MAX_WORDS`, 256: largest payload, in 32-bit words, that is accepted.
- `IFG_CYCLES`, 16: idle clocks between `txen` falling and the next grant; must be ≥ 12.
- `START_TIMEOUT`, 64: clocks to wait for `txen` to rise after `tx_start` before aborting.
- `clk`  in  1  single clock. All logic runs on the rising edge; the transmitter runs on the falling edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `src_req`  in  2  per-source level request, held until `src_done` or `src_rej`.
- `src_words0`, `src_words1`  in  16 each  payload length in 32-bit words.
- `src_data0`, `src_data1`  in  32 each  head word of each source FIFO (show-ahead).
- `src_rd`  out  2  per-source FIFO read strobe.
- `src_done`, `src_rej`  out  2 each  one-cycle per-source completion and rejection pulses.
- `tx_start`  out  1  start strobe to the transmitter.
- `tx_data_length`  out  16  UDP length in bytes.
- `tx_total_length`  out  16  IP total length in bytes.
- `data_req`  in  1  word request from the transmitter.
- `datain`  out  32  word to the transmitter.
- `txen`  in  1  transmitter GMII enable, monitored to track the frame.
- `grant`  out  2  one-hot owner; 0 when no source owns the transmitter.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky error flag; cleared only by reset.
- `frame_cnt`  out  16  number of completed frames; wraps at 65535→0.

## Operation
- States: IDLE → ARB → LOAD → START → BUSY → GAP → IDLE.
- IDLE: moves to ARB when any `src_req` bit is high.
- ARB: round-robin choice.
  - If both sources request, grant the source not served last.
  - After reset, the last-served pointer is 1, so source 0 wins the first tie.
  - The `grant` register is set in this state.
- LOAD: samples the granted source's word count W.
  - W = 0 or W > `MAX_WORDS`: pulse `src_rej[k]`, clear `grant`, return to IDLE, and do not move the last-served pointer.
  - Otherwise register `tx_data_length` = 8 + 4·W and `tx_total_length` = 28 + 4·W, both 16-bit. Zero the word counter.
- START: `tx_start` is held high until `txen` is sampled high, then move to BUSY.
  - If `START_TIMEOUT` clocks pass with `txen` still low, set `err`, pulse `src_rej[k]`, and go to GAP.
- BUSY:
  - `src_rd[k]` = `data_req & grant[k]`. `datain` = the granted source's data, combinational.
  - Each `data_req` cycle increments the word counter.
  - Once the counter has reached W, further `data_req` cycles are suppressed: `src_rd` = 0, `datain` = 0, and `err` is set.
  - On a `txen` 1→0 transition: pulse `src_done[k]`, increment `frame_cnt`, update the last-served pointer, and go to GAP.
- GAP: count `IFG_CYCLES` clocks, then clear `grant` and return to IDLE.
- A request that drops mid-frame is ignored; the frame completes.
- When not in BUSY, `src_rd` = 0 and `datain` = 0.

## Timing
- Reset values: `tx_start` 0, `grant` 0, `src_rd` 0, `src_done` 0, `src_rej` 0, `busy` 0, `err` 0, `frame_cnt` 0, both length outputs 0, `datain` 0, last-served pointer 1.
- Request to `tx_start` high: 3 clocks (IDLE, ARB, LOAD).
- Length outputs are stable from LOAD until the next LOAD.
- `txen` is produced on the falling edge and sampled on the rising edge, so no synchronizer is used.
- Minimum spacing between frames: `IFG_CYCLES` + 3 clocks from `txen` falling.
- `rst_n` asserted mid-frame clears every register immediately. The bench must assume the transmitter is reset in the same event.

## Configuration
- `UDP_TX_SCHED_TIMEOUT_EN` defined: the START timeout and a BUSY watchdog are compiled in.
  - BUSY watchdog: if `txen` stays high for more than 16·(W + 30) clocks, set `err`, pulse `src_rej[k]`, and go to GAP.
- Macro undefined: START waits for `txen` indefinitely, there is no BUSY watchdog, and `START_TIMEOUT` is unused.

## Structure
- Shared package `udp_pkg`:
  - state enum;
  - header constants UDP_HDR_BYTES = 8 and IP_HDR_BYTES = 20;
  - source index constants SRC_RADAR = 0 and SRC_STATUS = 1.
- One sub-module, `rr_arb2`: two-requester round-robin arbiter with a last-served pointer, producing a one-hot grant. Everything else lives in `udp_tx_scheduler`.

## Test plan
- Source 0 requests with W = 64 and a transmitter model:
  - `tx_data_length` = 264 and `tx_total_length` = 284;
  - `tx_start` rises 3 clocks after the request;
  - exactly 64 `src_rd[0]` pulses;
  - `src_done[0]` pulses once and `frame_cnt` = 1.
- Both sources request continuously, W = 4 each: grants alternate 0, 1, 0, 1, and `txen` stays low for ≥ 16 clocks between frames.
- Source 1 requests with W = 0, then with W = 257: `src_rej[1]` pulses each time, `tx_start` never rises, and `err` stays 0.
- Model issues 5 `data_req` for W = 4: the fifth gets `src_rd` = 0 and `datain` = 0, `err` rises, and the frame still completes.
- With `UDP_TX_SCHED_TIMEOUT_EN` defined and `txen` tied low: after 64 clocks `err` = 1, `src_rej` pulses, and after the gap the state returns to IDLE.
- `rst_n` asserted mid-BUSY: all outputs return to their reset values asynchronously, and the next request after release is granted to source 0.
